// File: rtl/poly_plot_sweep_if.sv
// poly_plot_sweep_if
// Bundles the sweep controller's command inputs and pixel-write outputs.
//   start, tick        : sweep start pulse and rate-divider advance request
//   coef_a/b/c         : signed polynomial coefficients (COEF_W bits each)
//   x, y, plot         : pixel column/row and one-cycle write strobe
//   busy, done         : sweep in progress, one-cycle end-of-sweep pulse
// master = the side that drives start/tick/coefs; slave = the sweep block.
interface poly_plot_sweep_if #(
  parameter int COEF_W = 8
);
  logic                     start;
  logic                     tick;
  logic signed [COEF_W-1:0] coef_a;
  logic signed [COEF_W-1:0] coef_b;
  logic signed [COEF_W-1:0] coef_c;
  logic [7:0]               x;
  logic [6:0]               y;
  logic                     plot;
  logic                     busy;
  logic                     done;

  modport master (
    output start, tick, coef_a, coef_b, coef_c,
    input  x, y, plot, busy, done
  );

  modport slave (
    input  start, tick, coef_a, coef_b, coef_c,
    output x, y, plot, busy, done
  );
endinterface

// File: rtl/poly_plot_sweep.sv
// poly_plot_sweep
// Sweeps screen columns 0..X_MAX-1, one column per rate-divider tick, and
// evaluates y = a*x^2 + b*x + c by forward differences. Each column whose
// row lands on screen produces a one-cycle pixel-write strobe.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high; returns to IDLE, clears outputs
//   bus    : poly_plot_sweep_if slave (start/tick/coefs in, x/y/plot/busy/done out)
//
// state | meaning
// IDLE  | waiting for start; coefficients latched on the start edge
// INIT  | load f and d1 for column 0 (only cycle using multipliers)
// WAIT  | waiting for tick; on tick register x/y/plot for this column
// EMIT  | strobe visible; last column goes to DONE
// STEP  | advance column, f += d1, d1 += 2a
// DONE  | one-cycle done pulse, busy already low
module poly_plot_sweep #(
  parameter int X_MAX  = 160,
  parameter int Y_MAX  = 120,
  parameter int COEF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  poly_plot_sweep_if.slave bus
);

  localparam int XOFF = X_MAX / 2;
  localparam int YOFF = Y_MAX / 2;
  localparam logic signed [31:0] XOFF_S  = 32'(XOFF);
  localparam logic signed [31:0] XOFF_SQ = 32'(XOFF * XOFF);
  localparam logic signed [31:0] D1_K    = 32'(1 - 2 * XOFF);
  localparam logic signed [31:0] YOFF_S  = 32'(YOFF);
  localparam logic signed [31:0] YLAST_S = 32'(Y_MAX - 1);
  localparam logic [7:0]         PX_LAST = 8'(X_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_EMIT, S_STEP, S_DONE
  } state_t;

  state_t state_q, state_n;

  logic [7:0]         px_q;
  logic signed [31:0] a_q, b_q, c_q, two_a_q;
  logic signed [31:0] f_q, d1_q;
  logic [7:0]         x_q;
  logic [6:0]         y_q;
  logic               plot_q, busy_q, done_q;

  logic               plot_n, done_n, busy_n, load_xy;
  logic signed [31:0] row;
  logic               on_screen;
  logic               last_col;

  // Screen row grows downward, so the math value is subtracted from the centre.
  assign row       = YOFF_S - f_q;
  assign on_screen = (row >= 32'sd0) && (row <= YLAST_S);
  assign last_col  = (px_q == PX_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    plot_n  = 1'b0;
    done_n  = 1'b0;
    load_xy = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_n = S_INIT;
      S_INIT: state_n = S_WAIT;
      S_WAIT: begin
        if (bus.tick) begin
          state_n = S_EMIT;
          load_xy = 1'b1;
          plot_n  = on_screen;
        end
      end
      S_EMIT: begin
        if (last_col) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          state_n = S_STEP;
        end
      end
      S_STEP: state_n = S_WAIT;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe: plot during EMIT, done during DONE.
  assign busy_n = (state_n == S_INIT) || (state_n == S_WAIT) ||
                  (state_n == S_EMIT) || (state_n == S_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      px_q    <= 8'd0;
      a_q     <= 32'sd0;
      b_q     <= 32'sd0;
      c_q     <= 32'sd0;
      two_a_q <= 32'sd0;
      f_q     <= 32'sd0;
      d1_q    <= 32'sd0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      plot_q <= plot_n;
      busy_q <= busy_n;
      done_q <= done_n;
      if (load_xy) begin
        x_q <= px_q;
        y_q <= row[6:0];
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= {{(32-COEF_W){bus.coef_a[COEF_W-1]}}, bus.coef_a};
            b_q     <= {{(32-COEF_W){bus.coef_b[COEF_W-1]}}, bus.coef_b};
            c_q     <= {{(32-COEF_W){bus.coef_c[COEF_W-1]}}, bus.coef_c};
            two_a_q <= {{(31-COEF_W){bus.coef_a[COEF_W-1]}}, bus.coef_a, 1'b0};
          end
        end
        S_INIT: begin
          // Column 0 sits at xm = -XOFF.
          px_q <= 8'd0;
          f_q  <= a_q * XOFF_SQ - b_q * XOFF_S + c_q;
          d1_q <= a_q * D1_K + b_q;
        end
        S_STEP: begin
          px_q <= px_q + 8'd1;
          f_q  <= f_q + d1_q;
          d1_q <= d1_q + two_a_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.x    = x_q;
  assign bus.y    = y_q;
  assign bus.plot = plot_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_poly_plot_sweep.sv
module tb_poly_plot_sweep;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  poly_plot_sweep_if #(.COEF_W(8)) bus ();

  poly_plot_sweep #(.X_MAX(160), .Y_MAX(120), .COEF_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // model: expected row per column, -1 when off screen
  int exp_y [160];
  int exp_n;
  // observations made by the compare process
  int obs_y   [160];
  int obs_cyc [160];
  int obs_n;
  int done_cnt;
  int done_cyc;
  logic prev_plot = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Full-precision polynomial evaluated directly per column.
  task automatic build_model(input int a, input int b, input int c);
    longint xm, f, r;
    exp_n = 0;
    for (int px = 0; px < 160; px++) begin
      xm = px - 80;
      f  = longint'(a) * xm * xm + longint'(b) * xm + longint'(c);
      r  = 60 - f;
      if (r >= 0 && r <= 119) begin
        exp_y[px] = int'(r);
        exp_n++;
      end else begin
        exp_y[px] = -1;
      end
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 160; i++) begin
      obs_y[i]   = -1;
      obs_cyc[i] = -1;
    end
    obs_n    = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // compare process
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.plot) begin
        check("plot_one_cycle", prev_plot, 0);
        if (bus.x < 8'd160) begin
          check("strobe_y", int'(bus.y), exp_y[bus.x]);
          obs_y[bus.x]   = int'(bus.y);
          obs_cyc[bus.x] = cyc;
          obs_n++;
        end else begin
          check("strobe_x_range", bus.x, 159);
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", bus.busy, 0);
      end
    end
    prev_plot = bus.plot;
  end

  task automatic run_sweep(input int a, input int b, input int c, input int period,
                           input int gap_at, input int start_at, input int reset_at);
    int cnt;
    bit stop;
    logic [7:0] gap_x;
    int gap_plots;
    build_model(a, b, c);
    clear_obs();
    bus.coef_a = 8'(a);
    bus.coef_b = 8'(b);
    bus.coef_c = 8'(c);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    cnt  = 0;
    stop = 0;
    gap_x = 8'd0;
    gap_plots = 0;
    while (!stop && done_cnt == 0 && cnt < 4000) begin
      if (gap_at >= 0 && cnt >= gap_at && cnt < gap_at + 50) bus.tick = 1'b0;
      else bus.tick = (cnt % period == 0);
      if (gap_at >= 0 && cnt == gap_at) begin
        gap_x = bus.x;
        gap_plots = obs_n;
      end
      if (gap_at >= 0 && cnt == gap_at + 50) begin
        check("gap_x_stable", bus.x, gap_x);
        check("gap_no_strobe", obs_n, gap_plots);
      end
      if (cnt == start_at) begin
        bus.start  = 1'b1;
        bus.coef_a = 8'sd5;
        bus.coef_b = -8'sd3;
        bus.coef_c = 8'sd9;
      end else begin
        bus.start = 1'b0;
      end
      reset = (cnt == reset_at);
      if (reset_at >= 0 && cnt == reset_at + 1) begin
        check("rst_plot", bus.plot, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
      end
      if (reset_at >= 0 && cnt == reset_at + 20) stop = 1;
      @(posedge clk); #1;
      cnt++;
    end
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    reset     = 1'b0;
    if (reset_at >= 0) begin
      check("rst_no_done", done_cnt, 0);
      check("rst_busy_idle", bus.busy, 0);
    end else begin
      check("done_seen", done_cnt, 1);
      repeat (5) @(posedge clk);
      #1;
      check("done_single", done_cnt, 1);
      check("busy_after_done", bus.busy, 0);
      check("strobe_count_model", obs_n, exp_n);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.tick   = 1'b0;
    bus.coef_a = '0;
    bus.coef_b = '0;
    bus.coef_c = '0;
    for (int i = 0; i < 160; i++) exp_y[i] = -1;
    clear_obs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_x", bus.x, 0);
    check("reset_y", bus.y, 0);
    check("reset_plot", bus.plot, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    @(posedge clk); #1 reset = 1'b0;

    // flat line at the centre row
    run_sweep(0, 0, 0, 4, -1, -1, -1);
    check("flat_count", obs_n, 160);
    check("flat_y0", obs_y[0], 60);
    check("flat_y159", obs_y[159], 60);

    // diagonal
    run_sweep(0, 1, 0, 4, -1, -1, -1);
    check("diag_count", obs_n, 120);
    check("diag_y21", obs_y[21], 119);
    check("diag_y140", obs_y[140], 0);
    check("diag_none20", obs_y[20], -1);
    check("diag_none141", obs_y[141], -1);

    // parabola and its mirror
    run_sweep(1, 0, 0, 4, -1, -1, -1);
    check("par_count", obs_n, 15);
    check("par_y73", obs_y[73], 11);
    check("par_y87", obs_y[87], 11);
    check("par_y80", obs_y[80], 60);
    check("par_none72", obs_y[72], -1);
    run_sweep(-1, 0, 0, 4, -1, -1, -1);
    check("npar_count", obs_n, 15);
    check("npar_y73", obs_y[73], 109);
    check("npar_y87", obs_y[87], 109);
    check("npar_y80", obs_y[80], 60);

    // tick held low 50 cycles mid-sweep
    run_sweep(0, 1, 0, 4, 203, -1, -1);
    check("gap_count", obs_n, 120);

    // tick every cycle: one column per 3 cycles
    run_sweep(0, 0, 0, 1, -1, -1, -1);
    check("fast_count", obs_n, 160);
    check("fast_period", obs_cyc[1] - obs_cyc[0], 3);
    check("fast_span", obs_cyc[159] - obs_cyc[0], 477);
    check("fast_done_lat", done_cyc - obs_cyc[159], 1);

    // start mid-sweep with other coefficients is ignored
    run_sweep(0, 1, 0, 4, -1, 162, -1);
    check("restart_ign_count", obs_n, 120);
    check("restart_ign_y140", obs_y[140], 0);

    // reset near column 90, then a fresh sweep starts at column 0
    run_sweep(0, 0, 0, 4, -1, -1, 362);
    run_sweep(0, 0, 0, 4, -1, -1, -1);
    check("fresh_count", obs_n, 160);
    check("fresh_y0", obs_y[0], 60);

    // extreme coefficients and a mixed case against the model
    run_sweep(-128, 127, -128, 3, -1, -1, -1);
    check("ext_count", obs_n, exp_n);
    run_sweep(2, -5, -40, 3, -1, -1, -1);
    check("mix_y80", obs_y[80], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
